triroc_clk_en_gen: RTL and testbench
====================================

// Module: triroc_clk_en_gen
// PURPOSE
//  Lock-supervised, parametrised clock-enable generator for the TRIROC readout fabric.
//  Runs on one fast clock (nominally MMCM 160 MHz) and derives NUM_CH single-cycle
//  enables plus square-wave divided clocks with per-channel divide ratios, all
//  phase-aligned to a common epoch. Sequences sync_reset from MMCM lock with a
//  stabilisation delay, re-enters reset on lock loss, counts lock losses and
//  supports runtime phase realignment.
// PARAMETERS
//  NUM_CH             3                    number of divided channels (1..8)
//  DIV_W              16                   width of each divide ratio
//  DIV_LIST           {16'd32,16'd8,16'd4} packed ratios, ch0 in LSBs (160->40/20/5 MHz)
//  LOCK_STABLE_CYCLES 1024                 cycles locked must hold before RUN (>=1)
//  LCC_W              8                    width of lock_loss_cnt
// PORTS
//  sys_clk        in   1        fast clock; all logic on rising edge
//  sys_reset      in   1        asynchronous, active-high reset
//  locked_in      in   1        MMCM LOCKED, asynchronous to sys_clk
//  realign        in   1        1-cycle pulse: restart all dividers at phase 0 (RUN only)
//  sync_reset     out  1        registered reset for downstream logic; 1 except in RUN
//  clk_en         out  NUM_CH   1-cycle enable per channel
//  clk_div        out  NUM_CH   registered divided square wave per channel
//  epoch          out  1        1-cycle pulse when all channels are at phase 0
//  lock_loss_cnt  out  LCC_W    saturating count of RUN->WAIT_LOCK transitions
// BEHAVIOUR
//  - Every DIV_i must be >= 2; anything else is an elaboration error ($error).
//  - Async reset values: sync_reset=1, clk_en=0, clk_div=0, epoch=0, lock_loss_cnt=0.
//    Async reset also forces state=WAIT_LOCK and clears all counters.
//  - locked_in passes through a 2-flop synchroniser to produce locked_s.
//  - FSM:
//    - WAIT_LOCK: locked_s=1 -> STABLE, stab_cnt=0.
//    - STABLE: locked_s=0 -> WAIT_LOCK (no count increment).
//      stab_cnt==LOCK_STABLE_CYCLES-1 -> RUN; otherwise stab_cnt++.
//    - RUN: locked_s=0 -> WAIT_LOCK and lock_loss_cnt++ (saturates at all-ones).
//  - Release latency: with locked_in steady high, sync_reset falls on rising edge
//    LOCK_STABLE_CYCLES+3, counting the edge that first samples locked_in=1 as edge 1.
//  - Lock-loss latency: sync_reset rises on the 3rd edge after locked_in falls, counting
//    the first sampling edge as edge 1. On that same edge clk_en, clk_div and epoch go to 0.
//  - Divider timing, for k = cycle index within RUN (k=0 is the first cycle sync_reset=0):
//    - clk_en[i]  = 1 iff (k mod DIV_i) == DIV_i-1. First pulse occurs at k=DIV_i-1.
//    - clk_div[i] = 1 iff (k mod DIV_i) < DIV_i/2 (integer division; odd DIV is high
//      for the shorter half).
//    - epoch = 1 iff every (k mod DIV_i)==0. This includes k=0.
//    - All are registered outputs, with no combinational path from any input.
//  - Counters wrap at DIV_i-1 -> 0 with no dropped or extra cycles.
//  - Outside RUN all divider outputs are held at 0.
//  - realign pulse in RUN at cycle k: cycle k+1 is treated as k=0, so epoch=1 and
//    clk_div=1 there. Any pending clk_en in cycle k+1 is suppressed.
//    realign outside RUN is ignored.
//  - realign in the same cycle as locked_s falling: lock loss wins (-> WAIT_LOCK).
//  - locked_in glitch shorter than 1 cycle may be missed; that is accepted by design.
// TESTING (bench with LOCK_STABLE_CYCLES=8, DIV_LIST={32,8,4})
//  - Reset, then locked_in=1 steady -> sync_reset low on edge 11; clk_en[0] pulses at
//    k=3,7,11; clk_en[1] at k=7,15; clk_en[2] at k=31; epoch at k=0,32,64.
//  - Drop locked_in at edge 5 of STABLE -> back to WAIT_LOCK, lock_loss_cnt stays 0.
//    Re-lock -> full 11-edge release.
//  - In RUN, drop locked_in -> sync_reset=1 on 3rd edge and all outputs 0; lock_loss_cnt=1.
//    Repeat 260 times with LCC_W=8 -> count saturates at 255.
//  - realign at k=5 -> epoch=1 and clk_div=3'b111 at next cycle. clk_en[0] next at +4,
//    clk_en[2] at +32. realign during WAIT_LOCK has no effect.
//  - Assert sys_reset asynchronously mid-RUN (between edges) -> outputs take reset
//    values immediately. Release -> full lock sequence is required again.
//  - DIV_LIST={16'd3} (NUM_CH=1) -> clk_div pattern 1,0,0 repeating; clk_en at k=2,5,8.

Source files
------------

// File: rtl/triroc_clk_en_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : triroc_clk_en_gen
// Lock-supervised clock-enable / divided-clock generator with a common epoch.
// Rev    : 1.0
// ============================================================================
module triroc_clk_en_gen #(
  parameter int                        NUM_CH             = 3,
  parameter int                        DIV_W              = 16,
  parameter logic [NUM_CH*DIV_W-1:0]   DIV_LIST           = {16'd32, 16'd8, 16'd4},
  parameter int                        LOCK_STABLE_CYCLES = 1024,
  parameter int                        LCC_W              = 8
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              locked_in,
  input  logic              realign,
  output logic              sync_reset,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_div,
  output logic              epoch,
  output logic [LCC_W-1:0]  lock_loss_cnt
);

  localparam int c_stab_w = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t                       r_state;
  logic [1:0]                   r_lock_sync;
  logic [c_stab_w-1:0]          r_stab_cnt;
  logic [NUM_CH-1:0][DIV_W-1:0] r_cnt;
  logic [NUM_CH-1:0][DIV_W-1:0] w_cnt_nxt;
  logic [NUM_CH-1:0]            w_en_nxt;
  logic [NUM_CH-1:0]            w_div_nxt;
  logic [NUM_CH-1:0]            w_phase0;
  logic                         w_locked_s;
  logic                         w_epoch_nxt;

  assign w_locked_s  = r_lock_sync[1];
  assign w_epoch_nxt = &w_phase0;

  if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
    $error("triroc_clk_en_gen: NUM_CH must be in 1..8");
  end
  if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable
    $error("triroc_clk_en_gen: LOCK_STABLE_CYCLES must be >= 1");
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [DIV_W-1:0] c_div = DIV_LIST[i*DIV_W +: DIV_W];
      if (c_div < 2) begin : g_bad_div
        $error("triroc_clk_en_gen: divide ratio of channel %0d must be >= 2", i);
      end
      // Outputs are precomputed from the next phase so they stay registered.
      assign w_cnt_nxt[i] = (realign || (r_cnt[i] == c_div - 1'b1)) ? '0 : r_cnt[i] + 1'b1;
      assign w_en_nxt[i]  = (w_cnt_nxt[i] == c_div - 1'b1);
      assign w_div_nxt[i] = (w_cnt_nxt[i] < (c_div >> 1));
      assign w_phase0[i]  = (w_cnt_nxt[i] == '0);
    end
  endgenerate

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state       <= ST_WAIT_LOCK;
      r_lock_sync   <= 2'b00;
      r_stab_cnt    <= '0;
      r_cnt         <= '0;
      sync_reset    <= 1'b1;
      clk_en        <= '0;
      clk_div       <= '0;
      epoch         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], locked_in};
      case (r_state)
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state    <= ST_STABLE;
            r_stab_cnt <= '0;
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            r_state <= ST_WAIT_LOCK;
          end else if (r_stab_cnt == c_stab_w'(LOCK_STABLE_CYCLES - 1)) begin
            // First RUN cycle is phase 0 on every channel.
            r_state    <= ST_RUN;
            sync_reset <= 1'b0;
            r_cnt      <= '0;
            clk_en     <= '0;
            clk_div    <= '1;
            epoch      <= 1'b1;
          end else begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            r_state    <= ST_WAIT_LOCK;
            sync_reset <= 1'b1;
            r_cnt      <= '0;
            clk_en     <= '0;
            clk_div    <= '0;
            epoch      <= 1'b0;
            if (lock_loss_cnt != '1) begin
              lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
          end else begin
            r_cnt   <= w_cnt_nxt;
            clk_en  <= w_en_nxt;
            clk_div <= w_div_nxt;
            epoch   <= w_epoch_nxt;
          end
        end
        default: begin
          r_state <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_triroc_clk_en_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_triroc_clk_en_gen
// Randomised scoreboard bench for triroc_clk_en_gen (ratios 32/8/4 and 3).
// Rev    : 1.0
// ============================================================================
module tb_triroc_clk_en_gen;

  localparam int L   = 8;
  localparam int NCH = 3;

  logic       sys_clk   = 1'b0;
  logic       sys_reset = 1'b1;
  logic       locked_in = 1'b0;
  logic       realign   = 1'b0;

  logic       sync_reset;
  logic [2:0] clk_en;
  logic [2:0] clk_div;
  logic       epoch;
  logic [7:0] lock_loss_cnt;

  logic       sync_reset3;
  logic [0:0] clk_en3;
  logic [0:0] clk_div3;
  logic       epoch3;
  logic [7:0] lock_loss_cnt3;

  int n_checks = 0;
  int n_errors = 0;

  triroc_clk_en_gen #(
    .NUM_CH(3), .DIV_W(16), .DIV_LIST({16'd32, 16'd8, 16'd4}),
    .LOCK_STABLE_CYCLES(L), .LCC_W(8)
  ) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .locked_in(locked_in), .realign(realign),
    .sync_reset(sync_reset), .clk_en(clk_en), .clk_div(clk_div), .epoch(epoch),
    .lock_loss_cnt(lock_loss_cnt)
  );

  triroc_clk_en_gen #(
    .NUM_CH(1), .DIV_W(16), .DIV_LIST(16'd3),
    .LOCK_STABLE_CYCLES(L), .LCC_W(8)
  ) dut3 (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .locked_in(locked_in), .realign(1'b0),
    .sync_reset(sync_reset3), .clk_en(clk_en3), .clk_div(clk_div3), .epoch(epoch3),
    .lock_loss_cnt(lock_loss_cnt3)
  );

  initial forever #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       sr;
    logic [2:0] en;
    logic [2:0] dv;
    logic       ep;
    logic [7:0] lcc;
    logic       en3;
    logic       dv3;
    logic       ep3;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned divs[3] = '{4, 8, 32};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: RUN holds once locked_in has been sampled high on
  // L+1 consecutive edges, seen through a two-edge synchroniser delay.
  int unsigned run0 = 0, run1 = 0, run2 = 0;
  bit          in_run = 1'b0;
  int unsigned k = 0, k3 = 0, lcc = 0;

  task automatic model_step();
    exp_t e;
    bit   prev;
    bit   all0;
    if (sys_reset) begin
      run0 = 0; run1 = 0; run2 = 0;
      in_run = 1'b0; k = 0; k3 = 0; lcc = 0;
      exp_q.delete();
    end else begin
      prev   = in_run;
      run2   = run1;
      run1   = run0;
      run0   = locked_in ? ((run0 < 1000) ? run0 + 1 : run0) : 0;
      in_run = (run2 >= L + 1);
      if (prev && !in_run && lcc < 255) lcc++;
      if (in_run) begin
        if (!prev)   begin k = 0; k3 = 0; end
        else begin
          k  = realign ? 0 : k + 1;
          k3 = k3 + 1;
        end
      end
    end
    e.sr  = !in_run;
    e.lcc = 8'(lcc);
    all0  = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      e.en[c] = in_run && ((k % divs[c]) == divs[c] - 1);
      e.dv[c] = in_run && ((k % divs[c]) < divs[c] / 2);
      if ((k % divs[c]) != 0) all0 = 1'b0;
    end
    e.ep  = in_run && all0;
    e.en3 = in_run && ((k3 % 3) == 2);
    e.dv3 = in_run && ((k3 % 3) < 1);
    e.ep3 = in_run && ((k3 % 3) == 0);
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge sys_clk or posedge sys_reset);
    model_step();
  end

  // Monitor: one expected entry per clock, compared on the falling edge.
  initial begin
    exp_t m;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        check("sync_reset",     sync_reset,     m.sr);
        check("clk_en",         clk_en,         m.en);
        check("clk_div",        clk_div,        m.dv);
        check("epoch",          epoch,          m.ep);
        check("lock_loss_cnt",  lock_loss_cnt,  m.lcc);
        check("div3_sync_rst",  sync_reset3,    m.sr);
        check("div3_clk_en",    clk_en3,        m.en3);
        check("div3_clk_div",   clk_div3,       m.dv3);
        check("div3_epoch",     epoch3,         m.ep3);
        check("div3_lcc",       lock_loss_cnt3, m.lcc);
      end
    end
  end

  task automatic step(input int n, input int rl_pct);
    for (int c = 0; c < n; c++) begin
      realign = (int'($urandom_range(0, 99)) < rl_pct);
      @(posedge sys_clk); #1;
    end
    realign = 1'b0;
  endtask

  task automatic wait_release(output int edges);
    edges = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge sys_clk); #1;
      if (!sync_reset) begin
        edges = n;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    repeat (3) @(posedge sys_clk);
    #1 sys_reset = 1'b0;
    step(4, 0);

    locked_in = 1'b1;
    wait_release(got);
    check("release_edges_first", got, 11);
    step(70, 0);

    locked_in = 1'b0;
    step(5, 0);
    locked_in = 1'b1;
    step(7, 0);
    locked_in = 1'b0;
    step(4, 0);
    locked_in = 1'b1;
    wait_release(got);
    check("release_after_stable_drop", got, 11);

    step(5, 0);
    realign = 1'b1;
    @(posedge sys_clk); #1;
    realign = 1'b0;
    check("realign_epoch", epoch, 1);
    check("realign_clk_div", clk_div, 3'b111);
    step(40, 0);

    locked_in = 1'b0;
    step(4, 0);
    realign = 1'b1;
    @(posedge sys_clk); #1;
    realign = 1'b0;
    step(2, 0);
    locked_in = 1'b1;
    wait_release(got);
    check("release_after_wait_realign", got, 11);
    step(20, 0);

    for (int it = 0; it < 260; it++) begin
      locked_in = 1'b0;
      step($urandom_range(3, 6), 20);
      locked_in = 1'b1;
      wait_release(got);
      check("release_edges_loop", got, 11);
      step($urandom_range(1, 30), 8);
    end
    check("lock_loss_cnt_saturated", lock_loss_cnt, 255);

    step(10, 0);
    @(posedge sys_clk); #2;
    sys_reset = 1'b1;
    #1;
    check("areset_sync_reset", sync_reset, 1);
    check("areset_clk_en", clk_en, 0);
    check("areset_clk_div", clk_div, 0);
    check("areset_epoch", epoch, 0);
    check("areset_lcc", lock_loss_cnt, 0);
    repeat (2) @(posedge sys_clk);
    #1 sys_reset = 1'b0;
    wait_release(got);
    check("release_after_areset", got, 11);
    step(100, 5);

    locked_in = 1'b0;
    step(5, 0);
    check("lcc_after_areset_loss", lock_loss_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
